// File: rtl/uart_vga_pkg.sv
// uart_vga_pkg: shared frame geometry defaults, pixel type and writer FSM states
package uart_vga_pkg;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_PIX_W  = 3;
    localparam int DEF_ADDR_W = 19;
    typedef logic [DEF_PIX_W-1:0] pixel_t;
    typedef enum logic [1:0] {IDLE, WRITE, LAST} wr_state_t;
endpackage

// File: rtl/uart_line_writer_pos_edge.sv
// pos_edge: registered rising-edge detect, pulse one cycle after the 0->1 sample
module pos_edge (
    input  logic clk,
    input  logic in,
    output logic out
);
    logic prev_q, prev_d, out_q, out_d;
    // next values: remember the last sample and flag a 0->1 transition
    always_comb begin
        prev_d = in;
        out_d  = in & ~prev_q;
    end
    // sample register
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        out_q  <= out_d;
    end
    assign out = out_q;
endmodule

// File: rtl/uart_line_writer.sv
// uart_line_writer: captures a received line and streams it pixel by pixel into the frame buffer.
// Define ROW_RANGE_CHECK_EN to reject rows >= HEIGHT and expose the sticky row_err output.
module uart_line_writer
    import uart_vga_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8:0]             line_row,
    input  logic [PIX_W*WIDTH-1:0] line_data,
    input  logic                   line_done,
    input  logic                   wr_ready,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [PIX_W-1:0]       wr_data,
    output logic                   busy,
    output logic                   line_written,
    output logic                   frame_done,
    output logic                   overrun,
`ifdef ROW_RANGE_CHECK_EN
    output logic                   row_err,
`endif
    input  logic                   clr_err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    wr_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [8:0] row_q, row_d;
    logic [PIX_W*WIDTH-1:0] shadow_q, shadow_d;
    logic overrun_q, overrun_d;
    logic line_edge, start;
`ifdef ROW_RANGE_CHECK_EN
    logic row_ok, row_err_q, row_err_d;
    assign row_ok  = 32'(line_row) < 32'(HEIGHT);
    assign row_err = row_err_q;
`else
    logic row_ok;
    assign row_ok = 1'b1;
`endif

    pos_edge u_edge (.clk(clk), .in(line_done), .out(line_edge));

    assign start        = line_edge && state_q == IDLE && row_ok;
    assign wr_en        = state_q == WRITE;
    assign wr_addr      = base_q + ADDR_W'(col_q);
    assign wr_data      = shadow_q[PIX_W*col_q +: PIX_W];
    assign busy         = state_q != IDLE;
    assign line_written = state_q == LAST;
    assign frame_done   = state_q == LAST && row_q == 9'(HEIGHT-1);
    assign overrun      = overrun_q;

    // next state: capture on edge in IDLE, advance column on each accepted write, flag dropped lines
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        base_d    = base_q;
        row_d     = row_q;
        shadow_d  = shadow_q;
        overrun_d = (overrun_q & ~clr_err) | (line_edge & (state_q != IDLE));
`ifdef ROW_RANGE_CHECK_EN
        row_err_d = (row_err_q & ~clr_err) | (line_edge & (state_q == IDLE) & ~row_ok);
`endif
        case (state_q)
            IDLE: if (start) begin
                shadow_d = line_data;
                row_d    = line_row;
                base_d   = ADDR_W'(32'(line_row) * 32'(WIDTH));
                col_d    = '0;
                state_d  = WRITE;
            end
            WRITE: if (wr_ready) begin
                col_d   = (col_q == CW'(WIDTH-1)) ? '0 : col_q + 1'b1;
                state_d = (col_q == CW'(WIDTH-1)) ? LAST : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous reset aborting any line in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            base_q    <= '0;
            row_q     <= '0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
`ifdef ROW_RANGE_CHECK_EN
            row_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            base_q    <= base_d;
            row_q     <= row_d;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
`ifdef ROW_RANGE_CHECK_EN
            row_err_q <= row_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_line_writer.sv
// tb_uart_line_writer: scoreboard bench, stimulus queues expected writes/line events, monitor checks them
module tb_uart_line_writer;
    localparam int W = 8, H = 4, P = 3, A = 5;
    logic clk = 0, rst = 1, line_done = 0, wr_ready = 1, clr_err = 0;
    logic [8:0] line_row = '0;
    logic [P*W-1:0] line_data = '0;
    logic wr_en, busy, line_written, frame_done, overrun;
    logic [A-1:0] wr_addr;
    logic [P-1:0] wr_data;
`ifdef ROW_RANGE_CHECK_EN
    logic row_err;
`endif
    int checks = 0, fails = 0, lines_seen = 0, acc_count = 0;
    logic [7:0] exp_w[$];
    logic exp_l[$];
    logic toggle = 0;
    logic [3:0] pat = 4'b1001;
    logic stall_prev = 0;
    logic [7:0] stall_val;

    uart_line_writer #(.WIDTH(W), .HEIGHT(H), .PIX_W(P), .ADDR_W(A)) dut (
        .clk(clk), .rst(rst), .line_row(line_row), .line_data(line_data), .line_done(line_done),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .line_written(line_written), .frame_done(frame_done), .overrun(overrun),
`ifdef ROW_RANGE_CHECK_EN
        .row_err(row_err),
`endif
        .clr_err(clr_err));

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [P*W-1:0] mk_line(int off);
        logic [P*W-1:0] d;
        for (int k = 0; k < W; k++) d[P*k +: P] = P'((k + off) % 8);
        return d;
    endfunction

    // ready driver: constant 1 or the repeating 1,0,0,1 pattern
    initial begin
        int pi = 0;
        forever begin
            @(posedge clk); #1;
            if (toggle) begin wr_ready = pat[3-pi]; pi = (pi + 1) % 4; end
            else wr_ready = 1;
        end
    end

    // monitor: pops expectations whenever the DUT presents a write or line completion
    initial begin
        forever begin
            @(negedge clk);
            if (rst) stall_prev = 0;
            else begin
                if (stall_prev && wr_en) check("stall_hold", {wr_addr, wr_data}, stall_val);
                if (wr_en && wr_ready) begin
                    acc_count++;
                    if (exp_w.size() == 0) check("unexpected_write", {wr_addr, wr_data}, 32'hFFFF_FFFF);
                    else check("write_addr_data", {wr_addr, wr_data}, exp_w.pop_front());
                end
                stall_prev = wr_en && !wr_ready;
                stall_val = {wr_addr, wr_data};
                if (line_written) begin
                    lines_seen++;
                    if (exp_l.size() == 0) check("unexpected_line", 1, 0);
                    else check("frame_done", frame_done, exp_l.pop_front());
                end else if (frame_done) check("frame_done_alone", 1, 0);
            end
        end
    end

    task automatic pulse_line(logic [8:0] row, logic [P*W-1:0] data);
        @(posedge clk); #1;
        line_row = row; line_data = data; line_done = 1;
        @(posedge clk); #1;
        line_done = 0;
        @(posedge clk); #1;
        line_data = ~data;
        line_row = 9'h1FF;
    endtask

    task automatic send_line(logic [8:0] row, int off);
        for (int k = 0; k < W; k++) exp_w.push_back({A'(row * W + k), P'((k + off) % 8)});
        exp_l.push_back(row == 9'(H - 1));
        pulse_line(row, mk_line(off));
    endtask

    task automatic wait_lines(int n);
        int t = 0;
        while (lines_seen < n && t < 200) begin @(negedge clk); t++; end
        check("line_timeout", lines_seen >= n, 1);
    endtask

    task automatic wait_acc(int n);
        int t = 0;
        while (acc_count < n && t < 200) begin @(negedge clk); t++; end
        check("accept_timeout", acc_count >= n, 1);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_outputs", {wr_en, busy, line_written, frame_done, overrun}, 0);
        @(posedge clk); #1 rst = 0;
        // 1: row 2, data 0..7
        send_line(2, 0);
        @(negedge clk);
        check("busy_during_line", busy, 1);
        wait_lines(1);
        check("q_empty_1", exp_w.size(), 0);
        @(negedge clk);
        check("busy_after_line", busy, 0);
        // 2: row 3, frame_done
        send_line(3, 0);
        wait_lines(2);
        check("q_empty_2", exp_w.size(), 0);
        // 3: ready toggling
        toggle = 1;
        send_line(0, 3);
        wait_lines(3);
        toggle = 0;
        check("q_empty_3", exp_w.size(), 0);
        // 4: overlapping edge at pixel 4 of row 1
        base = acc_count;
        send_line(1, 5);
        wait_acc(base + 4);
        pulse_line(3, mk_line(2));
        wait_lines(4);
        repeat (12) @(negedge clk);
        check("no_extra_line", lines_seen, 4);
        check("q_empty_4", exp_w.size(), 0);
        check("overrun_set", overrun, 1);
        @(posedge clk); #1 clr_err = 1;
        @(posedge clk); #1 clr_err = 0;
        @(negedge clk);
        check("overrun_clr", overrun, 0);
        // 5: reset after 3 accepted writes
        base = acc_count;
        send_line(0, 1);
        wait_acc(base + 3);
        rst = 1;
        @(negedge clk);
        check("rst_mid_wr_en_busy", {wr_en, busy}, 0);
        exp_w.delete();
        exp_l.delete();
        rst = 0;
        repeat (3) @(negedge clk);
        check("no_write_after_rst", acc_count, base + 3);
        send_line(2, 6);
        wait_lines(5);
        check("q_empty_5", exp_w.size(), 0);
`ifdef ROW_RANGE_CHECK_EN
        // 6: out-of-range row rejected
        base = acc_count;
        pulse_line(5, mk_line(4));
        repeat (4) @(negedge clk);
        check("row_err_set", row_err, 1);
        check("row_err_busy", busy, 0);
        repeat (12) @(negedge clk);
        check("row_err_no_writes", acc_count, base);
        @(posedge clk); #1 clr_err = 1;
        @(posedge clk); #1 clr_err = 0;
        @(negedge clk);
        check("row_err_clr", row_err, 0);
`else
        // 6: out-of-range row wraps modulo 2^ADDR_W (5*8 = 40 -> 8)
        for (int k = 0; k < W; k++) exp_w.push_back({A'(8 + k), P'((k + 4) % 8)});
        exp_l.push_back(1'b0);
        pulse_line(5, mk_line(4));
        wait_lines(6);
        check("q_empty_6", exp_w.size(), 0);
`endif
        check("lines_final", exp_l.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
